systolic_tile_sequencer: RTL
============================

Name: systolic_tile_sequencer

Overview:
- Host-side sequencer for the 3x3 systolic convolution array.
- Accepts a serial byte stream on a valid/ready handshake: 16 image bytes, then 9 filter bytes.
- Presents them as a parallel 4x4 tile and 3x3 filter, releases the array's reset for a fixed compute window, and captures the 2x2 result.
- Streams the four result bytes back out on a valid/ready handshake.

Parameters:
- LATENCY, 12, number of cycles the array runs with arr_rst low before results are captured (legal range 1..255).
- DW, 8, byte width of pixels, weights and results.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data holds a valid byte.
- in_ready  out  1  sequencer accepts a byte this cycle.
- in_data  in  DW  pixel/weight byte, row-major order.
- reuse_flt  in  1  sampled on the last image-byte handshake; 1 = keep the stored filter and skip filter load.
- img_flat  out  16*DW  tile to array; byte i_rc at bits [DW*(4r+c) +: DW].
- flt_flat  out  9*DW  filter to array; byte f_rc at bits [DW*(3r+c) +: DW].
- arr_rst  out  1  reset to the array; low only during RUN.
- res_flat  in  4*DW  array outputs; o_rc at bits [DW*(2r+c) +: DW].
- out_valid  out  1  out_data holds a valid result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DW  result byte, order o00, o01, o10, o11.
- tile_done  out  1  one-cycle pulse on the handshake of o11.

Behaviour:
- States and transitions:
  - LOAD_IMG -> LOAD_FLT, or -> RUN when reuse_flt=1 and flt_loaded=1.
  - LOAD_FLT -> RUN.
  - RUN -> DRAIN.
  - DRAIN -> LOAD_IMG.
- Reset (rst=1):
  - State LOAD_IMG; byte index 0; run counter 0; drain index 0.
  - Image, filter and result registers all 0; flt_loaded=0.
  - arr_rst=1; out_valid=0; tile_done=0; out_data=0; in_ready=0 while rst is high.
- Reset mid-operation behaves identically from any state. Partial loads are discarded and pending results are dropped.
- in_ready = 1 in LOAD_IMG and LOAD_FLT (when rst=0), else 0. A byte is accepted only on in_valid && in_ready.
- LOAD_IMG: the k-th accepted byte (k=0..15) is written to image slot k. On k=15:
  - if reuse_flt=1 and flt_loaded=1, go to RUN;
  - otherwise go to LOAD_FLT with the index cleared.
- LOAD_FLT: the k-th byte (k=0..8) is written to filter slot k. On k=8, set flt_loaded=1 and go to RUN.
- reuse_flt=1 while flt_loaded=0 is ignored; the filter is loaded normally.
- img_flat and flt_flat are driven directly from registers and change only on accepted bytes.
- RUN:
  - arr_rst=0 on every RUN cycle (exactly LATENCY cycles); the counter runs 0..LATENCY-1.
  - On the cycle the counter equals LATENCY-1, res_flat is registered into the result regs and the state goes to DRAIN.
  - arr_rst returns to 1 on the first DRAIN cycle.
- DRAIN:
  - out_valid=1 and out_data = result[drain index].
  - The index advances only on out_valid && out_ready.
  - out_data and out_valid stay stable while out_ready=0, with no timeout.
  - On the handshake of index 3: tile_done=1 for that cycle, next state LOAD_IMG, indices cleared.
- Back-to-back: the first byte of the next tile can be accepted the cycle after tile_done.
- Image and filter registers hold their values across tiles until overwritten.
- Widths: no arithmetic beyond the counters. The byte index is 4 bits and wraps only by state change. The run counter is 8 bits.

Test Plan:
- Basic tile: send image 9,8,2,6,0,4,1,6,4,10,1,1,2,2,9,9, then filter 3,2,0,2,0,1,3,1,1. Drive out_ready=1 with the array connected (or a valid-correlation model) -> arr_rst low for exactly 12 cycles; out bytes 67,74,34,59; tile_done on the 4th.
- Filter reuse: second tile with image all 1s and reuse_flt=1 -> no filter bytes accepted (in_ready drops after the 16th byte); outputs 13,13,13,13.
- Reuse before any filter: after reset, set reuse_flt=1 and send 25 bytes as in the basic tile -> filter is loaded; outputs 67,74,34,59.
- Backpressure: out_ready=0 for 20 cycles in DRAIN, then toggle 1/0 each cycle -> out_data holds 67 during the stall; each byte is emitted exactly once, in order; in_valid pulses in DRAIN are not accepted.
- Stall on input: in_valid low on alternate cycles -> same outputs; byte count is exact.
- Mid-operation reset: rst=1 for 1 cycle during RUN counter=5 -> arr_rst=1, out_valid=0, flt_loaded=0, img_flat=0; the next full 25-byte load produces 67,74,34,59.

Source files
------------

// File: rtl/systolic_tile_sequencer.sv
// systolic_tile_sequencer
// Host-side sequencer for a 3x3 systolic convolution array. Collects a 4x4
// image tile and a 3x3 filter from a byte stream, holds the array out of
// reset for a fixed compute window, captures the 2x2 result and streams the
// four result bytes back out.
module systolic_tile_sequencer #(
    parameter int LATENCY = 12,
    parameter int DW      = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic            reuse_flt,
    output logic [16*DW-1:0] img_flat,
    output logic [9*DW-1:0] flt_flat,
    output logic            arr_rst,
    input  logic [4*DW-1:0] res_flat,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic            tile_done
);

    localparam logic [1:0] S_LOAD_IMG = 2'd0;
    localparam logic [1:0] S_LOAD_FLT = 2'd1;
    localparam logic [1:0] S_RUN      = 2'd2;
    localparam logic [1:0] S_DRAIN    = 2'd3;

    localparam logic [7:0] LAST_RUN   = 8'(LATENCY - 1);
    localparam logic [3:0] LAST_IMG   = 4'd15;
    localparam logic [3:0] LAST_FLT   = 4'd8;
    localparam logic [1:0] LAST_DRAIN = 2'd3;

    logic [1:0]    r_state;
    logic [3:0]    r_byte_idx;
    logic [7:0]    r_run_cnt;
    logic [1:0]    r_drain_idx;
    logic          r_flt_loaded;
    logic [DW-1:0] r_img [16];
    logic [DW-1:0] r_flt [9];
    logic [DW-1:0] r_res [4];

    logic w_in_hs;
    logic w_out_hs;
    logic w_img_wr;
    logic w_flt_wr;
    logic w_img_last;
    logic w_flt_last;
    logic w_run_last;
    logic w_drain_last;
    logic w_skip_flt;

    // Handshakes and per-state qualifiers shared by the blocks below.
    assign in_ready     = ~rst & ((r_state == S_LOAD_IMG) | (r_state == S_LOAD_FLT));
    assign w_in_hs      = in_valid & in_ready;
    assign out_valid    = ~rst & (r_state == S_DRAIN);
    assign w_out_hs     = out_valid & out_ready;
    assign w_img_wr     = w_in_hs & (r_state == S_LOAD_IMG);
    assign w_flt_wr     = w_in_hs & (r_state == S_LOAD_FLT);
    assign w_img_last   = w_img_wr & (r_byte_idx == LAST_IMG);
    assign w_flt_last   = w_flt_wr & (r_byte_idx == LAST_FLT);
    assign w_run_last   = (r_state == S_RUN) & (r_run_cnt == LAST_RUN);
    assign w_drain_last = w_out_hs & (r_drain_idx == LAST_DRAIN);
    // A reuse request only counts once a filter has actually been loaded.
    assign w_skip_flt   = reuse_flt & r_flt_loaded;

    // The array is only let out of reset while the sequencer is in RUN.
    assign arr_rst   = rst | (r_state != S_RUN);
    assign out_data  = r_res[r_drain_idx];
    assign tile_done = w_drain_last;

    // Flatten the stored tile and filter; bus outputs come straight from registers.
    for (genvar g = 0; g < 16; g++) begin : g_img_flat
        assign img_flat[DW*g +: DW] = r_img[g];
    end
    for (genvar g = 0; g < 9; g++) begin : g_flt_flat
        assign flt_flat[DW*g +: DW] = r_flt[g];
    end

    // Sequencer state, byte index, run counter, drain index and filter-valid flag.
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_LOAD_IMG;
            r_byte_idx   <= '0;
            r_run_cnt    <= '0;
            r_drain_idx  <= '0;
            r_flt_loaded <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD_IMG: begin
                    if (w_img_last) begin
                        r_byte_idx <= '0;
                        r_state    <= w_skip_flt ? S_RUN : S_LOAD_FLT;
                    end else if (w_img_wr) begin
                        r_byte_idx <= r_byte_idx + 4'd1;
                    end
                end
                S_LOAD_FLT: begin
                    if (w_flt_last) begin
                        r_byte_idx   <= '0;
                        r_flt_loaded <= 1'b1;
                        r_state      <= S_RUN;
                    end else if (w_flt_wr) begin
                        r_byte_idx <= r_byte_idx + 4'd1;
                    end
                end
                S_RUN: begin
                    if (w_run_last) begin
                        r_run_cnt <= '0;
                        r_state   <= S_DRAIN;
                    end else begin
                        r_run_cnt <= r_run_cnt + 8'd1;
                    end
                end
                S_DRAIN: begin
                    if (w_drain_last) begin
                        r_drain_idx <= '0;
                        r_state     <= S_LOAD_IMG;
                    end else if (w_out_hs) begin
                        r_drain_idx <= r_drain_idx + 2'd1;
                    end
                end
                default: r_state <= S_LOAD_IMG;
            endcase
        end
    end

    // Image slot write on each accepted image byte.
    // NOTE: the byte arrays are reset because reset must present an all-zero
    // tile and filter to the array; they are small enough to stay flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) r_img[i] <= '0;
        end else if (w_img_wr) begin
            r_img[r_byte_idx] <= in_data;
        end
    end

    // Filter slot write on each accepted filter byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) r_flt[i] <= '0;
        end else if (w_flt_wr) begin
            r_flt[r_byte_idx] <= in_data;
        end
    end

    // Capture the array outputs on the final cycle of the compute window.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_res[i] <= '0;
        end else if (w_run_last) begin
            for (int i = 0; i < 4; i++) r_res[i] <= res_flat[DW*i +: DW];
        end
    end

endmodule
